// File: rtl/rom_loader.sv
// Serial iNES loader: receives 8N1 UART bytes and turns each accepted byte into one ROM write strobe.
// Latency: wr_en follows the stop-bit sample by two cycles (byte_valid register, then write register).
// Backpressure: none; the ROM store must accept every strobe. Bad or unexpected bytes are dropped.
module rom_loader #(
    parameter int CLKS_PER_BIT = 217,
    parameter int ROM_BYTES    = 'h6010
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        din,
    input  logic        prg_ctrl,
    output logic        wr_en,
    output logic [14:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code
);

    localparam int             HALF    = CLKS_PER_BIT / 2;
    localparam int             CW      = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  HALF_M1 = CW'(HALF - 1);
    localparam logic [CW-1:0]  FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [14:0]    LAST    = 15'(ROM_BYTES - 1);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [1:0] {L_IDLE, L_LOAD, L_DONE, L_ERR}   ld_state_t;

    logic            din_s1;
    logic            rxs;
    rx_state_t       rx_state;
    logic [CW-1:0]   clk_cnt;
    logic [2:0]      bit_cnt;
    logic [7:0]      shift_reg;
    logic            byte_valid;
    logic            frame_err;

    ld_state_t       ld_state;
    logic [14:0]     byte_cnt;
    logic            prg_prev;
    logic            prg_rise;
    logic            prg_fall;

    assign prg_rise = prg_ctrl & ~prg_prev;
    assign prg_fall = ~prg_ctrl & prg_prev;

    // Expected iNES magic plus 1x16k PRG / 1x8k CHR size bytes.
    function automatic logic [7:0] hdr_byte(input logic [2:0] idx);
        case (idx)
            3'd0:    hdr_byte = 8'h4E;
            3'd1:    hdr_byte = 8'h45;
            3'd2:    hdr_byte = 8'h53;
            3'd3:    hdr_byte = 8'h1A;
            default: hdr_byte = 8'h01;
        endcase
    endfunction

    // Two-flop synchronizer on the asynchronous RX line (idle high).
    always_ff @(posedge clk) begin
        if (rst) begin
            din_s1 <= 1'b1;
            rxs    <= 1'b1;
        end else begin
            din_s1 <= din;
            rxs    <= din_s1;
        end
    end

    // UART receiver: mid-bit sampling, start-bit glitch rejection, one-cycle result pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state   <= R_IDLE;
            clk_cnt    <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (rx_state)
                R_IDLE: begin
                    clk_cnt <= '0;
                    bit_cnt <= '0;
                    if (!rxs) rx_state <= R_START;
                end
                R_START: begin
                    if (clk_cnt == HALF_M1) begin
                        clk_cnt  <= '0;
                        rx_state <= rxs ? R_IDLE : R_DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                R_DATA: begin
                    if (clk_cnt == FULL_M1) begin
                        clk_cnt   <= '0;
                        shift_reg <= {rxs, shift_reg[7:1]};
                        bit_cnt   <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) rx_state <= R_STOP;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                R_STOP: begin
                    if (clk_cnt == FULL_M1) begin
                        clk_cnt  <= '0;
                        rx_state <= R_IDLE;
                        if (rxs) byte_valid <= 1'b1;
                        else     frame_err  <= 1'b1;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                default: rx_state <= R_IDLE;
            endcase
        end
    end

    // Loader FSM: session control, header check, write strobe and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ld_state <= L_IDLE;
            byte_cnt <= '0;
            prg_prev <= 1'b0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            err_code <= 2'd0;
        end else begin
            prg_prev <= prg_ctrl;
            wr_en    <= 1'b0;
            if (prg_rise) begin
                // A new session always wins; any byte completing this cycle is dropped.
                ld_state <= L_LOAD;
                byte_cnt <= '0;
                busy     <= 1'b1;
                done     <= 1'b0;
                err      <= 1'b0;
                err_code <= 2'd0;
            end else if (ld_state == L_LOAD) begin
                if (prg_fall) begin
                    ld_state <= L_ERR;
                    busy     <= 1'b0;
                    err      <= 1'b1;
                    err_code <= 2'd3;
                end else if (frame_err) begin
                    ld_state <= L_ERR;
                    busy     <= 1'b0;
                    err      <= 1'b1;
                    err_code <= 2'd2;
                end else if (byte_valid) begin
                    if (byte_cnt < 15'd6 && shift_reg != hdr_byte(byte_cnt[2:0])) begin
                        ld_state <= L_ERR;
                        busy     <= 1'b0;
                        err      <= 1'b1;
                        err_code <= 2'd1;
                    end else begin
                        wr_en   <= 1'b1;
                        wr_addr <= byte_cnt;
                        wr_data <= shift_reg;
                        // Terminal check comes before the increment, so the counter never wraps.
                        if (byte_cnt == LAST) begin
                            ld_state <= L_DONE;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule
